mod_inv: RTL and testbench

MOD_INV -- requirements
Module: mod_inv

---
 rtl/ntt_pkg.sv | 20 ++
 rtl/mod_mul_seq.sv | 53 +++++
 rtl/mod_inv.sv | 144 ++++++++++++++
 tb/tb_mod_inv.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and constants for the modular-arithmetic blocks.
// MOD_INV_LAT is the accept-to-result latency of mod_inv at W_DEF.
package ntt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_SQR,
    S_DONE
  } state_t;

  localparam int W_DEF       = 8;
  localparam int MOD_INV_LAT = 2 * W_DEF * W_DEF + 2;

  function automatic int mod_inv_lat(input int w);
    return 2 * w * w + 2;
  endfunction

endpackage

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier, MSB-first interleaved shift-add.
// Operands are read live; start clears the accumulator, W steps follow.
module mod_mul_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] modulus,
  output logic         done,
  output logic [W-1:0] p
);

  localparam logic [W-1:0] SEL_MSB = W'(1) << (W - 1);

  logic [W-1:0] r_acc;
  logic [W-1:0] r_sel;
  logic [W+1:0] w_s0;
  logic [W+1:0] w_s1;
  logic [W+1:0] w_s2;
  logic [W+1:0] w_m;
  logic         w_bit;

  assign w_m   = {2'b00, modulus};
  assign w_bit = |(b & r_sel);

  // 2*acc + a < 3*modulus, so two conditional subtracts fully reduce
  always_comb begin
    w_s0 = {1'b0, r_acc, 1'b0};
    if (w_bit) w_s0 = w_s0 + {2'b00, a};
    w_s1 = (w_s0 >= w_m) ? w_s0 - w_m : w_s0;
    w_s2 = (w_s1 >= w_m) ? w_s1 - w_m : w_s1;
  end

  assign p    = W'(w_s2);
  assign done = r_sel[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sel <= '0;
    end else if (start) begin
      r_acc <= '0;
      r_sel <= SEL_MSB;
    end else if (|r_sel) begin
      r_acc <= p;
      r_sel <= r_sel >> 1;
    end
  end

endmodule

// File: rtl/mod_inv.sv
// Modular inverse by Fermat exponentiation, a^(modulus-2) mod modulus.
// Define MOD_INV_CHECK_EN to reject invalid operands with err early.
module mod_inv
  import ntt_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] modulus,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] inv,
  output logic         err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_mod;
  logic [W-1:0]  r_e;
  logic [W-1:0]  r_res;
  logic [W-1:0]  r_base;
  logic [W-1:0]  r_inv;
  logic [IW-1:0] r_idx;
  logic          r_first;
  logic          r_bad;
  logic          r_out_valid;
  logic          r_err;

  logic          w_start;
  logic          w_done;
  logic          w_bad;
  logic          w_last;
  logic [W-1:0]  w_ma;
  logic [W-1:0]  w_p;

`ifdef MOD_INV_CHECK_EN
  assign w_bad = (r_a == '0) || (r_a >= r_mod) || (r_mod < W'(2));
`else
  assign w_bad = 1'b0;
`endif

  assign w_last = (r_idx == IW'(W - 1));
  assign w_ma   = (r_state == S_SQR) ? r_base : r_res;

  // Next product starts on the same edge the previous one commits
  assign w_start =
    (r_state == S_MUL && r_first && !r_bad) ||
    (w_done && (r_state == S_MUL ||
                (r_state == S_SQR && !w_last)));

  mod_mul_seq #(
    .W(W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_start),
    .a       (w_ma),
    .b       (r_base),
    .modulus (r_mod),
    .done    (w_done),
    .p       (w_p)
  );

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign inv       = r_inv;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_mod       <= '0;
      r_e         <= '0;
      r_res       <= '0;
      r_base      <= '0;
      r_inv       <= '0;
      r_idx       <= '0;
      r_first     <= 1'b0;
      r_bad       <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_mod   <= modulus;
            r_e     <= modulus - W'(2);
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_res   <= W'(1);
          r_base  <= r_a;
          r_idx   <= '0;
          r_bad   <= w_bad;
          r_first <= 1'b1;
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_first <= 1'b0;
          if (r_bad) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_err       <= 1'b1;
            r_inv       <= '0;
          end else if (w_done) begin
            if (r_e[r_idx]) r_res <= w_p;
            r_state <= S_SQR;
          end
        end
        S_SQR: begin
          if (w_done) begin
            r_base <= w_p;
            if (w_last) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_err       <= 1'b0;
              r_inv       <= r_res;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_MUL;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv.sv
// Directed bench for mod_inv at W=8.
// Covers latency, known inverses, a mod-251 sweep, backpressure and reset.
module tb_mod_inv;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] modulus = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] inv;
  logic         err;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mod_inv #(
    .W(W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .modulus   (modulus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inv       (inv),
    .err       (err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  task automatic accept(input int ta, input int tm);
    int n;
    n = 0;
    @(negedge clk);
    a = W'(ta);
    modulus = W'(tm);
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input int ta, input int tm,
                     output int r_inv, output int r_err,
                     output int lat);
    accept(ta, tm);
    wait_out(lat);
    r_inv = int'(inv);
    r_err = int'(err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v, e, lat, seen;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_inv", int'(inv), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    run(3, 17, v, e, lat);
    check("m17_a3_inv", v, 6);
    check("m17_a3_err", e, 0);
    check("m17_a3_lat", lat, 130);

    run(16, 17, v, e, lat);
    check("m17_a16", v, 16);
    run(1, 17, v, e, lat);
    check("m17_a1", v, 1);
    run(2, 17, v, e, lat);
    check("m17_a2", v, 9);
    run(1, 2, v, e, lat);
    check("m2_a1", v, 1);
    run(2, 251, v, e, lat);
    check("m251_a2", v, 126);
    run(250, 251, v, e, lat);
    check("m251_a250", v, 250);

    for (int i = 1; i < 251; i++) begin
      run(i, 251, v, e, lat);
      check($sformatf("sweep251_a%0d", i), (i * v) % 251, 1);
    end

`ifdef MOD_INV_CHECK_EN
    run(0, 17, v, e, lat);
    check("chk_a0_err", e, 1);
    check("chk_a0_inv", v, 0);
    check("chk_a0_lat", lat, 2);
    run(20, 17, v, e, lat);
    check("chk_a20_err", e, 1);
    check("chk_a20_inv", v, 0);
    check("chk_a20_lat", lat, 2);
`else
    run(0, 17, v, e, lat);
    check("nochk_a0_err", e, 0);
    check("nochk_a0_lat", lat, 130);
`endif

    out_ready = 1'b0;
    accept(5, 17);
    repeat (20) @(posedge clk);
    @(negedge clk);
    a = W'(3);
    in_valid = 1'b1;
    check("busy_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    check("bp_inv", int'(inv), 7);
    check("bp_err", int'(err), 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_inv", int'(inv), 7);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    a = W'(3);
    modulus = W'(17);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_out_valid", int'(out_valid), 0);
    check("hs_idle_ready", int'(in_ready), 1);
    in_valid = 1'b0;

    accept(7, 17);
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rst_valid", int'(out_valid), 0);
    check("abort_rst_inv", int'(inv), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("abort_no_out", seen, 0);
    run(3, 17, v, e, lat);
    check("post_rst_inv", v, 6);
    check("post_rst_lat", lat, 130);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
